// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the 5-stage LoongArch pipeline.
//   Pre-IF computes nextpc and issues it to a synchronous inst SRAM
//   (1-cycle read latency). The IF register holds the fetched {inst, pc}
//   and hands it to decode over a valid/allowin handshake. Branch
//   redirects from decode either steer the current request or are parked
//   in br_pending until the stage can advance. The SRAM word is buffered
//   while decode stalls, because the SRAM output is not held.
//
// Optional feature: define IF_ADEF_CHECK_EN to flag misaligned fetch
//   addresses (fs_excp_adef) instead of issuing them to the SRAM.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   ds_allowin        decode can accept an instruction this cycle
//   br_taken/target   redirect pulse and target from decode
//   fs_to_ds_valid    fs_to_ds_bus carries a valid instruction
//   fs_to_ds_bus      {inst[31:0], pc[31:0]}
//   fs_excp_adef      fetch address error travelling with the bus
//   inst_sram_*       SRAM request / response
module if_stage #(
  parameter logic [31:0] RESET_PC        = 32'h1c000000,
  parameter int          FS_TO_DS_BUS_WD = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic                       br_taken,
  input  logic [31:0]                br_target,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       fs_excp_adef,
  output logic                       inst_sram_en,
  output logic [3:0]                 inst_sram_we,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic [31:0]                inst_sram_rdata
);

  logic        fs_valid;
  logic [31:0] fs_pc;
  logic        br_pending;
  logic [31:0] br_pending_target;
  logic        inst_buf_valid;
  logic [31:0] inst_buf;

  logic        to_fs_valid;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic        advance;
  logic [31:0] nextpc;
  logic [31:0] fs_inst;
  logic [31:0] bus_inst;

  // pre-IF
  assign to_fs_valid = ~reset;
  assign nextpc      = br_taken   ? br_target :
                       br_pending ? br_pending_target :
                                    fs_pc + 32'd4;

  // handshake
  assign fs_ready_go    = 1'b1;
  assign fs_allowin     = ~fs_valid | (fs_ready_go & ds_allowin);
  assign advance        = to_fs_valid & fs_allowin;
  // anything in fs while a redirect is live or parked is wrong-path
  assign fs_to_ds_valid = fs_valid & fs_ready_go & ~br_taken & ~br_pending;

  assign inst_sram_we    = 4'h0;
  assign inst_sram_wdata = 32'h0;
  assign inst_sram_addr  = nextpc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_pc    <= RESET_PC - 32'd4;
      fs_valid <= 1'b0;
    end else if (advance) begin
      fs_pc    <= nextpc;
      fs_valid <= 1'b1;
    end
  end

  // redirect that arrives while fs cannot advance is parked; a later
  // redirect overwrites it, and the advance that consumes it clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_pending        <= 1'b0;
      br_pending_target <= 32'h0;
    end else if (advance) begin
      br_pending        <= 1'b0;
    end else if (br_taken) begin
      br_pending        <= 1'b1;
      br_pending_target <= br_target;
    end
  end

  // rdata is only good for one cycle; grab it on the first stall cycle
  // and serve it from the buffer until fs advances
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_buf_valid <= 1'b0;
      inst_buf       <= 32'h0;
    end else if (advance) begin
      inst_buf_valid <= 1'b0;
    end else if (fs_valid && !ds_allowin && !inst_buf_valid) begin
      inst_buf_valid <= 1'b1;
      inst_buf       <= inst_sram_rdata;
    end
  end

  assign fs_inst = inst_buf_valid ? inst_buf : inst_sram_rdata;

`ifdef IF_ADEF_CHECK_EN
  logic nextpc_misalign;
  logic adef_q;

  assign nextpc_misalign = |nextpc[1:0];
  // misaligned fetches never reach the SRAM; decode raises ADEF instead
  assign inst_sram_en    = advance & ~nextpc_misalign;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        adef_q <= 1'b0;
    else if (advance) adef_q <= nextpc_misalign;
  end

  assign fs_excp_adef = adef_q;
  assign bus_inst     = adef_q ? 32'h0 : fs_inst;
`else
  assign inst_sram_en = advance;
  assign fs_excp_adef = 1'b0;
  assign bus_inst     = fs_inst;
`endif

  assign fs_to_ds_bus = {bus_inst, fs_pc};

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        fs_excp_adef;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'h0;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        adef;
  } exp_t;

  exp_t sb[$];

`ifdef IF_ADEF_CHECK_EN
  localparam bit ADEF = 1'b1;
`else
  localparam bit ADEF = 1'b0;
`endif

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ds_allowin      (ds_allowin),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_bus    (fs_to_ds_bus),
    .fs_excp_adef    (fs_excp_adef),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return ~a ^ 32'h1234_5678;
  endfunction

  // SRAM model: data only for the cycle after a request, garbage otherwise
  always @(posedge clk)
    inst_sram_rdata <= inst_sram_en ? word(inst_sram_addr) : $urandom;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // scoreboard: every accepted transfer must match the next expectation
  always @(negedge clk) begin
    #2;
    if (reset === 1'b0 && fs_to_ds_valid && ds_allowin) begin
      if (sb.size() == 0) begin
        chk("xfer_unexpected", {32'h0, fs_to_ds_bus[31:0]}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("xfer_bus", fs_to_ds_bus, {e.inst, e.pc});
        chk("xfer_adef", {63'h0, fs_excp_adef}, {63'h0, e.adef});
      end
    end
  end

  task automatic drv(input logic rst, input logic al, input logic bt, input logic [31:0] tg);
    @(negedge clk);
    reset      = rst;
    ds_allowin = al;
    br_taken   = bt;
    br_target  = tg;
    #1;
  endtask

  function automatic exp_t mk(input logic [31:0] pc);
    exp_t e;
    e.inst = word(pc);
    e.pc   = pc;
    e.adef = 1'b0;
    return e;
  endfunction

  initial begin
    exp_t ea;
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    exp_t ea;
    reset = 1'b1; ds_allowin = 1'b1; br_taken = 1'b0; br_target = 32'h0;

    sb.push_back(mk(32'h1c000000));
    sb.push_back(mk(32'h1c000004));
    sb.push_back(mk(32'h1c000100));
    sb.push_back(mk(32'h1c000200));
    sb.push_back(mk(32'h1c000000));
    sb.push_back(mk(32'h1c000004));
    ea.pc   = 32'h1c000102;
    ea.inst = ADEF ? 32'h0 : word(32'h1c000102);
    ea.adef = ADEF;
    sb.push_back(ea);

    // reset state
    @(negedge clk); #1;
    chk("rst_valid", {63'h0, fs_to_ds_valid}, 64'h0);
    chk("rst_en",    {63'h0, inst_sram_en}, 64'h0);
    chk("rst_we",    {60'h0, inst_sram_we}, 64'h0);
    chk("rst_wdata", {32'h0, inst_sram_wdata}, 64'h0);
    chk("rst_adef",  {63'h0, fs_excp_adef}, 64'h0);

    // first fetch and streaming
    drv(0, 1, 0, 0);
    chk("a1_en",    {63'h0, inst_sram_en}, 64'h1);
    chk("a1_addr",  {32'h0, inst_sram_addr}, 64'h1c000000);
    chk("a1_valid", {63'h0, fs_to_ds_valid}, 64'h0);
    drv(0, 1, 0, 0);
    chk("a2_valid", {63'h0, fs_to_ds_valid}, 64'h1);
    chk("a2_addr",  {32'h0, inst_sram_addr}, 64'h1c000004);

    // 3-cycle decode stall at pc 1c000004, SRAM output goes to garbage
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 0);
      chk("stall_en",    {63'h0, inst_sram_en}, 64'h0);
      chk("stall_valid", {63'h0, fs_to_ds_valid}, 64'h1);
      chk("stall_bus",   fs_to_ds_bus, {word(32'h1c000004), 32'h1c000004});
    end
    drv(0, 1, 0, 0);
    chk("resume_bus",  fs_to_ds_bus, {word(32'h1c000004), 32'h1c000004});
    chk("resume_en",   {63'h0, inst_sram_en}, 64'h1);
    chk("resume_addr", {32'h0, inst_sram_addr}, 64'h1c000008);

    // redirect with fs_allowin=1: squash 1c000008, fetch target now
    drv(0, 1, 1, 32'h1c000100);
    chk("br_valid", {63'h0, fs_to_ds_valid}, 64'h0);
    chk("br_en",    {63'h0, inst_sram_en}, 64'h1);
    chk("br_addr",  {32'h0, inst_sram_addr}, 64'h1c000100);
    drv(0, 1, 0, 0);
    chk("br_tgt_pc", {32'h0, fs_to_ds_bus[31:0]}, 64'h1c000100);
    chk("br_next",   {32'h0, inst_sram_addr}, 64'h1c000104);

    // redirect during stall: parked until decode frees up
    drv(0, 0, 1, 32'h1c000200);
    chk("pend_valid0", {63'h0, fs_to_ds_valid}, 64'h0);
    chk("pend_en0",    {63'h0, inst_sram_en}, 64'h0);
    drv(0, 0, 0, 0);
    chk("pend_valid1", {63'h0, fs_to_ds_valid}, 64'h0);
    chk("pend_en1",    {63'h0, inst_sram_en}, 64'h0);
    drv(0, 1, 0, 0);
    chk("pend_valid2", {63'h0, fs_to_ds_valid}, 64'h0);
    chk("pend_en2",    {63'h0, inst_sram_en}, 64'h1);
    chk("pend_addr",   {32'h0, inst_sram_addr}, 64'h1c000200);
    drv(0, 1, 0, 0);
    chk("pend_pc",     {32'h0, fs_to_ds_bus[31:0]}, 64'h1c000200);
    chk("pend_next",   {32'h0, inst_sram_addr}, 64'h1c000204);

    // mid-stream reset with fs_valid=1 and a parked redirect
    drv(0, 0, 1, 32'h1c000300);
    chk("pre_rst_valid", {63'h0, fs_to_ds_valid}, 64'h0);
    drv(1, 1, 0, 0);
    chk("mrst_valid", {63'h0, fs_to_ds_valid}, 64'h0);
    chk("mrst_en",    {63'h0, inst_sram_en}, 64'h0);
    drv(0, 1, 0, 0);
    chk("refetch_en",   {63'h0, inst_sram_en}, 64'h1);
    chk("refetch_addr", {32'h0, inst_sram_addr}, 64'h1c000000);
    drv(0, 1, 0, 0);
    drv(0, 1, 0, 0);
    chk("refetch_addr2", {32'h0, inst_sram_addr}, 64'h1c000008);

    // misaligned redirect target
    drv(0, 1, 1, 32'h1c000102);
    chk("mis_addr", {32'h0, inst_sram_addr}, 64'h1c000102);
    chk("mis_en",   {63'h0, inst_sram_en}, {63'h0, ~ADEF});
    drv(0, 1, 0, 0);
    chk("mis_valid", {63'h0, fs_to_ds_valid}, 64'h1);
    chk("mis_adef",  {63'h0, fs_excp_adef}, {63'h0, ADEF});
    drv(0, 0, 0, 0);
    chk("end_en", {63'h0, inst_sram_en}, 64'h0);

    @(negedge clk); #3;
    chk("sb_empty", 64'(sb.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
